// File: rtl/reg_file_pkg.sv
// Shared defaults, register-number type and address qualification helper
// for the register file and its read ports.
package reg_file_pkg;

  localparam int unsigned RF_DATA_W   = 32;
  localparam int unsigned RF_NUM_REGS = 32;
  localparam int unsigned RF_ADDR_W   = 5;

  typedef logic [RF_ADDR_W-1:0] reg_num_t;

  // A register number is live when it names real storage other than r0.
  function automatic logic reg_num_live(input int unsigned num, input int unsigned num_regs);
    return (num != 32'd0) && (num < num_regs);
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// One write port and two read ports of the register file, bundled as a bus.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) ();

  logic [ADDR_W-1:0] wr_num;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [ADDR_W-1:0] rd0_num;
  logic [DATA_W-1:0] rd0_data;
  logic [ADDR_W-1:0] rd1_num;
  logic [DATA_W-1:0] rd1_data;

  modport master (
    output wr_num, wr_data, wr_en, rd0_num, rd1_num,
    input  rd0_data, rd1_data
  );

  modport slave (
    input  wr_num, wr_data, wr_en, rd0_num, rd1_num,
    output rd0_data, rd1_data
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// Combinational read port: r0 and out-of-range numbers read zero, and a
// same-cycle write to the addressed register is forwarded unless in reset.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned ADDR_W   = RF_ADDR_W
) (
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_num,
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_num,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic              rd_live_s;
  logic              bypass_s;
  logic [DATA_W-1:0] stored_s;

  // Qualify the read number, pick stored data, then apply the write-through bypass.
  always_comb begin
    rd_live_s = reg_num_live(32'(rd_num), NUM_REGS);
    // rd_live_s already implies wr_num names a writable register when they match.
    bypass_s  = !reset && wr_en && rd_live_s && (wr_num == rd_num);
    stored_s  = {DATA_W{1'b0}};
    if (rd_live_s) begin
      stored_s = regs[rd_num];
    end else begin
      stored_s = {DATA_W{1'b0}};
    end
    if (bypass_s) begin
      rd_data = wr_data;
    end else begin
      rd_data = stored_s;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Register file: NUM_REGS x DATA_W storage, one write port, two independent
// combinational read ports with write-through bypass; r0 is hard-wired zero.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS,
  parameter int unsigned ADDR_W   = RF_ADDR_W
) (
  input logic         clk,
  input logic         reset,
  reg_file_if.slave   bus
);

  if (ADDR_W != $clog2(NUM_REGS)) begin : g_bad_addr_w
    $error("reg_file: ADDR_W must equal clog2(NUM_REGS)");
  end

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic              wr_live_s;

  // Writes to r0 or to numbers beyond the storage are dropped here.
  always_comb begin
    wr_live_s = bus.wr_en && reg_num_live(32'(bus.wr_num), NUM_REGS);
  end

  // Storage update: reset clears everything and wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_live_s) begin
      regs_r[bus.wr_num] <= bus.wr_data;
    end
  end

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rd0 (
    .reset   (reset),
    .rd_num  (bus.rd0_num),
    .regs    (regs_r),
    .wr_en   (bus.wr_en),
    .wr_num  (bus.wr_num),
    .wr_data (bus.wr_data),
    .rd_data (bus.rd0_data)
  );

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rd1 (
    .reset   (reset),
    .rd_num  (bus.rd1_num),
    .regs    (regs_r),
    .wr_en   (bus.wr_en),
    .wr_num  (bus.wr_num),
    .wr_data (bus.wr_data),
    .rd_data (bus.rd1_data)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// compared against an array-based model of the register file.
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;
  logic [31:0] model [32];

  reg_file_if rf_if ();

  reg_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rf_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected read value straight from the rules: r0 is zero, a live write forwards.
  function automatic logic [31:0] exp_rd(input logic [4:0] n);
    if (n == 5'd0) return 32'h0000_0000;
    if (!reset && rf_if.wr_en && rf_if.wr_num == n) return rf_if.wr_data;
    return model[n];
  endfunction

  task automatic drive(input logic rst, input logic we, input logic [4:0] wn,
                       input logic [31:0] wd, input logic [4:0] r0, input logic [4:0] r1);
    reset         = rst;
    rf_if.wr_en   = we;
    rf_if.wr_num  = wn;
    rf_if.wr_data = wd;
    rf_if.rd0_num = r0;
    rf_if.rd1_num = r1;
  endtask

  task automatic check_reads(input string tag);
    #1;
    check_val($sformatf("%s_rd0_r%0d", tag, rf_if.rd0_num), rf_if.rd0_data, exp_rd(rf_if.rd0_num));
    check_val($sformatf("%s_rd1_r%0d", tag, rf_if.rd1_num), rf_if.rd1_data, exp_rd(rf_if.rd1_num));
  endtask

  task automatic clock_edge();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0000_0000;
    end else if (rf_if.wr_en && rf_if.wr_num != 5'd0) begin
      model[rf_if.wr_num] = rf_if.wr_data;
    end
    #1;
  endtask

  initial begin
    reg_num_t    wn, r0, r1;
    logic [31:0] wd;
    logic        we, rst;

    for (int i = 0; i < 32; i++) model[i] = 32'hXXXX_XXXX;
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    clock_edge();

    // Everything reads zero after reset.
    for (int r = 0; r < 32; r++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(r), 5'(31 - r));
      #1;
      check_val($sformatf("rst_rd0_r%0d", r), rf_if.rd0_data, 32'h0000_0000);
      check_val($sformatf("rst_rd1_r%0d", 31 - r), rf_if.rd1_data, 32'h0000_0000);
    end

    // r29, r31, r30 written on successive cycles.
    drive(1'b0, 1'b1, 5'd29, 32'h8012_0000, 5'd0, 5'd0); clock_edge();
    drive(1'b0, 1'b1, 5'd31, 32'h0000_0000, 5'd0, 5'd0); clock_edge();
    drive(1'b0, 1'b1, 5'd30, 32'h8012_0000, 5'd0, 5'd0); clock_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd29, 5'd30);
    #1;
    check_val("seq_r29", rf_if.rd0_data, 32'h8012_0000);
    check_val("seq_r30", rf_if.rd1_data, 32'h8012_0000);

    // Writes to r0 vanish, both in the bypass and in storage.
    drive(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
    #1;
    check_val("r0_wr_same_rd0", rf_if.rd0_data, 32'h0000_0000);
    check_val("r0_wr_same_rd1", rf_if.rd1_data, 32'h0000_0000);
    clock_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #1;
    check_val("r0_wr_next_rd0", rf_if.rd0_data, 32'h0000_0000);
    check_val("r0_wr_next_rd1", rf_if.rd1_data, 32'h0000_0000);

    // Write-through bypass on r5, seen on both ports.
    drive(1'b0, 1'b1, 5'd5, 32'h1111_1111, 5'd0, 5'd0); clock_edge();
    drive(1'b0, 1'b1, 5'd5, 32'h2222_2222, 5'd5, 5'd5);
    #1;
    check_val("byp_same_rd0", rf_if.rd0_data, 32'h2222_2222);
    check_val("byp_same_rd1", rf_if.rd1_data, 32'h2222_2222);
    clock_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    #1;
    check_val("byp_after_rd0", rf_if.rd0_data, 32'h2222_2222);

    // Disabled write leaves r7 alone and does not bypass.
    drive(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 5'd0, 5'd0); clock_edge();
    drive(1'b0, 1'b0, 5'd7, 32'hFFFF_FFFF, 5'd7, 5'd7);
    #1;
    check_val("wr_dis_same", rf_if.rd0_data, 32'hA5A5_A5A5);
    clock_edge();
    #1;
    check_val("wr_dis_after", rf_if.rd1_data, 32'hA5A5_A5A5);

    // Reset beats a simultaneous write and suppresses the bypass.
    drive(1'b0, 1'b1, 5'd3, 32'h0000_0055, 5'd0, 5'd0); clock_edge();
    drive(1'b1, 1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd3);
    #1;
    check_val("rst_nobyp", rf_if.rd0_data, 32'h0000_0055);
    clock_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
    #1;
    check_val("rst_prio_r3", rf_if.rd0_data, 32'h0000_0000);
    check_val("rst_clr_r7", rf_if.rd1_data, 32'h0000_0000);
    drive(1'b0, 1'b1, 5'd3, 32'h1234_5678, 5'd0, 5'd0); clock_edge();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    #1;
    check_val("post_rst_wr", rf_if.rd0_data, 32'h1234_5678);

    // Randomized traffic, reads biased towards the register being written.
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      we  = ($urandom_range(0, 3) != 0);
      wn  = reg_num_t'($urandom);
      wd  = $urandom;
      r0  = ($urandom_range(0, 2) == 0) ? wn : reg_num_t'($urandom);
      r1  = ($urandom_range(0, 2) == 0) ? wn : reg_num_t'($urandom);
      drive(rst, we, wn, wd, r0, r1);
      check_reads("rand");
      clock_edge();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, default 32, register and data-port width in bits.
REQ-002 Parameter NUM_REGS, default 32, number of architectural registers.
REQ-003 Parameter ADDR_W, default 5, register-number width; SHALL equal clog2(NUM_REGS).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-006 wr_num  input  ADDR_W  destination register number for the write port.
REQ-007 wr_data  input  DATA_W  data to write.
REQ-008 wr_en  input  1  write enable, active-high.
REQ-009 rd0_num  input  ADDR_W  read port 0 register number.
REQ-010 rd0_data  output  DATA_W  read port 0 data.
REQ-011 rd1_num  input  ADDR_W  read port 1 register number.
REQ-012 rd1_data  output  DATA_W  read port 1 data.

Function
REQ-013 Storage SHALL be NUM_REGS registers of DATA_W bits, indexed 0..NUM_REGS-1.
REQ-014 Register 0 SHALL read as all-zero at all times; writes to register 0 SHALL be discarded.
REQ-015 On rising clk with reset=0, wr_en=1, wr_num!=0: register[wr_num] SHALL take wr_data; all other registers SHALL hold.
REQ-016 wr_en=0 SHALL leave all registers unchanged.
REQ-017 Read ports SHALL be combinational: rdN_data follows rdN_num and the register contents in the same cycle, zero clock latency.
REQ-018 Write-through bypass: if wr_en=1, wr_num!=0 and rdN_num==wr_num, rdN_data SHALL equal wr_data combinationally in that cycle; otherwise rdN_data SHALL equal the stored value.
REQ-019 Both read ports SHALL be fully independent; both may address the same register, including the one being written, with identical results.
REQ-020 Register numbers >= NUM_REGS (possible only when NUM_REGS < 2^ADDR_W) SHALL read zero and SHALL be ignored for writes.
REQ-021 Exactly one register write per cycle at most; no other side effects.

Reset
REQ-022 On rising clk with reset=1, all registers SHALL become zero; reset SHALL take priority over a simultaneous write.
REQ-023 During reset, the bypass SHALL be suppressed; read outputs SHALL reflect stored values (zero after the first reset edge).
REQ-024 Reset asserted mid-operation SHALL clear all contents on that edge; the first write after reset deassertion SHALL be honoured normally.

Structure
REQ-025 A shared package reg_file_pkg SHALL hold DATA_W, NUM_REGS, ADDR_W defaults and a register-number typedef reg_num_t.
REQ-026 One sub-module, reg_file_rd_port (zero-check, range check, bypass mux), SHALL be instantiated once per read port.
REQ-027 Storage SHALL be a single array written in one clocked process; no latches.

Verification
REQ-028 Reset, then read r0..r31 on both ports -> every rd0_data/rd1_data = 0x00000000.
REQ-029 Write r29=0x80120000, then r31=0x00000000 and r30=0x80120000 on successive cycles; read rd0_num=29, rd1_num=30 -> 0x80120000, 0x80120000.
REQ-030 wr_en=1, wr_num=0, wr_data=0xDEADBEEF; read r0 on both ports same and next cycle -> 0x00000000.
REQ-031 r5 holds 0x11111111; same cycle wr_en=1, wr_num=5, wr_data=0x22222222, rd0_num=5 -> rd0_data=0x22222222 that cycle and after the edge.
REQ-032 wr_en=0, wr_num=7, wr_data=0xFFFFFFFF -> r7 unchanged.
REQ-033 reset=1 together with wr_en=1, wr_num=3, wr_data=0x12345678 -> r3=0 after the edge; write r3 next cycle with reset=0 -> r3=0x12345678.
